// File: rtl/usb_tx.sv
// USB full/low-speed transmit engine: SYNC, NRZI, bit stuffing, EOP.
// Define USB_TX_CRC16_EN to append CRC16 after the last byte.
module usb_tx #(
  parameter int unsigned DIV = 4,
  parameter logic        LS  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       valid,
  input  logic       last,
  output logic       ready,
  output logic       busy,
  output logic       underrun,
  output logic       send,
  output logic       dp,
  output logic       dn
);

  localparam int unsigned    CW       = $clog2(DIV);
  localparam logic [CW-1:0]  CMAX     = CW'(DIV - 1);
  localparam logic [7:0]     SYNC_PAT = 8'h80;
  localparam logic           J_DP     = ~LS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_CRC,
    S_STUFF,
    S_EOP0,
    S_EOPJ
  } state_e;

  state_e        state_q, state_d;
  state_e        ret_q, ret_d;
  state_e        nst;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic          last_q, last_d;
  logic [2:0]    ones_q, ones_d;
  logic          line_q, line_d;
  logic          send_q, send_d;
  logic          dp_q, dp_d;
  logic          dn_q, dn_d;
  logic          busy_q, busy_d;
  logic          ur_q, ur_d;
  logic          strobe;
  logic          adv;
  logic          stuff;
  logic          bit_v;

`ifdef USB_TX_CRC16_EN
  logic [15:0] crc_q, crc_d;

  // Reflected form of poly 0x8005, so the register shifts out LSB first
  function automatic logic [15:0] crc_upd(
    input logic [15:0] c,
    input logic [7:0]  d
  );
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 16'hA001;
      else             r = r >> 1;
    end
    return r;
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    last_d  = last_q;
    ones_d  = ones_q;
    line_d  = line_q;
    send_d  = send_q;
    dp_d    = dp_q;
    dn_d    = dn_q;
    busy_d  = busy_q;
    ur_d    = ur_q;
`ifdef USB_TX_CRC16_EN
    crc_d   = crc_q;
`endif
    ready   = 1'b0;
    nst     = state_q;
    adv     = 1'b0;
    stuff   = 1'b0;
    bit_v   = 1'b0;
    strobe  = busy_q && (cnt_q == CMAX);
    cnt_d   = (busy_q && !strobe) ? cnt_q + 1'b1 : '0;

    unique case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (valid) begin
          adv    = 1'b1;
          nst    = S_SYNC;
          idx_d  = '0;
          sh_d   = data;
          last_d = last;
          ur_d   = 1'b0;
`ifdef USB_TX_CRC16_EN
          crc_d  = 16'hFFFF;
`endif
        end
      end
      S_SYNC: begin
        if (strobe) begin
          adv = 1'b1;
          if (idx_q == 4'd7) begin
            nst   = S_DATA;
            idx_d = '0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (strobe) begin
          adv = 1'b1;
          if (idx_q != 4'd7) begin
            idx_d = idx_q + 4'd1;
            sh_d  = {1'b0, sh_q[7:1]};
          end else begin
            ready = !last_q;
            idx_d = '0;
            if (last_q) begin
`ifdef USB_TX_CRC16_EN
              nst   = S_CRC;
              crc_d = ~crc_q;
`else
              nst   = S_EOP0;
`endif
            end else if (valid) begin
              nst    = S_DATA;
              sh_d   = data;
              last_d = last;
`ifdef USB_TX_CRC16_EN
              crc_d  = crc_upd(crc_q, data);
`endif
            end else begin
              nst  = S_EOP0;
              ur_d = 1'b1;
            end
          end
        end
      end
      S_CRC: begin
`ifdef USB_TX_CRC16_EN
        if (strobe) begin
          adv = 1'b1;
          if (idx_q == 4'd15) begin
            nst   = S_EOP0;
            idx_d = '0;
          end else begin
            idx_d = idx_q + 4'd1;
            crc_d = crc_q >> 1;
          end
        end
`else
        nst = S_IDLE;
        adv = 1'b1;
`endif
      end
      S_STUFF: begin
        if (strobe) begin
          adv = 1'b1;
          nst = ret_q;
        end
      end
      S_EOP0: begin
        if (strobe) begin
          adv = 1'b1;
          if (idx_q == 4'd1) begin
            nst   = S_EOPJ;
            idx_d = '0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      S_EOPJ: begin
        if (strobe) begin
          adv = 1'b1;
          nst = S_IDLE;
        end
      end
      default: begin
        adv = 1'b1;
        nst = S_IDLE;
      end
    endcase

    case (nst)
      S_SYNC:  bit_v = SYNC_PAT[idx_d[2:0]];
      S_DATA:  bit_v = sh_d[0];
`ifdef USB_TX_CRC16_EN
      S_CRC:   bit_v = crc_d[0];
`endif
      default: bit_v = 1'b0;
    endcase

    // The sixth consecutive one forces a stuffed zero ahead of whatever follows
    if (adv) begin
      stuff  = (state_q == S_SYNC || state_q == S_DATA ||
                state_q == S_CRC) && (ones_q == 3'd6);
      send_d = 1'b1;
      busy_d = 1'b1;
      if (stuff) begin
        state_d = S_STUFF;
        ret_d   = nst;
        line_d  = ~line_q;
        ones_d  = '0;
      end else begin
        state_d = nst;
        if (nst == S_EOP0 || nst == S_EOPJ) begin
          line_d = 1'b1;
          ones_d = '0;
        end else if (nst == S_IDLE) begin
          line_d = 1'b1;
          ones_d = '0;
          send_d = 1'b0;
          busy_d = 1'b0;
        end else begin
          line_d = bit_v ? line_q : ~line_q;
          ones_d = bit_v ? ones_q + 3'd1 : 3'd0;
        end
      end
      if (!stuff && nst == S_EOP0) begin
        dp_d = 1'b0;
        dn_d = 1'b0;
      end else begin
        dp_d = line_d ^ LS;
        dn_d = ~(line_d ^ LS);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ret_q   <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      last_q  <= 1'b0;
      ones_q  <= '0;
      line_q  <= 1'b1;
      send_q  <= 1'b0;
      dp_q    <= J_DP;
      dn_q    <= ~J_DP;
      busy_q  <= 1'b0;
      ur_q    <= 1'b0;
`ifdef USB_TX_CRC16_EN
      crc_q   <= 16'hFFFF;
`endif
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      last_q  <= last_d;
      ones_q  <= ones_d;
      line_q  <= line_d;
      send_q  <= send_d;
      dp_q    <= dp_d;
      dn_q    <= dn_d;
      busy_q  <= busy_d;
      ur_q    <= ur_d;
`ifdef USB_TX_CRC16_EN
      crc_q   <= crc_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign underrun = ur_q;
  assign send     = send_q;
  assign dp       = dp_q;
  assign dn       = dn_q;

endmodule
